// File: rtl/bf16_exp_sub.sv
// ---------------------------------------------------------------------------
// bf16_exp_sub : two-stage BF16 divide exponent path (ea - eb + BIAS),
//                with saturation, per-result and sticky ovf/unf status.
// Optional: define BF16_EXP_SUB_EVCNT_EN to add the evt_count port/counter.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bf16_exp_sub #(
  parameter int EXP_W = 8,
  parameter int BIAS  = 127
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] result,
  output logic             res_ovf,
  output logic             res_unf,
  output logic             res_dbz,
  output logic             overflow_status,
  output logic             underflow_status
`ifdef BF16_EXP_SUB_EVCNT_EN
  ,
  output logic [7:0]       evt_count
`endif
);

  localparam int DW = EXP_W + 2;
  localparam logic signed [DW-1:0] BIAS_W = DW'(BIAS);
  localparam logic signed [DW-1:0] OVF_TH = DW'((2 ** EXP_W) - 1);
  localparam logic signed [DW-1:0] ZERO_W = '0;

  logic                    s1_valid_q, s2_valid_q;
  logic signed [DW-1:0]    s1_d_q, s1_d_d;
  logic                    s1_za_q, s1_zb_q;
  logic [EXP_W-1:0]        result_q, result_d;
  logic                    ovf_q, ovf_d, unf_q, unf_d, dbz_q, dbz_d;
  logic                    ovf_sts_q, ovf_sts_d, unf_sts_q, unf_sts_d;
  logic                    s1_advance, in_xfer, out_xfer;

  assign s1_advance = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready   = ~s1_valid_q | s1_advance;
  assign in_xfer    = in_valid & in_ready;
  assign out_xfer   = s2_valid_q & out_ready;

  // Zero-extended operands keep the difference exact before the bias is added.
  assign s1_d_d = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + BIAS_W;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_d_q     <= '0;
      s1_za_q    <= 1'b0;
      s1_zb_q    <= 1'b0;
    end else begin
      if (in_xfer) begin
        s1_valid_q <= 1'b1;
        s1_d_q     <= s1_d_d;
        s1_za_q    <= (exp_a == '0);
        s1_zb_q    <= (exp_b == '0);
      end else if (s1_advance) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    result_d = s1_d_q[EXP_W-1:0];
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    dbz_d    = 1'b0;
    if (s1_zb_q) begin
      result_d = '1;
      dbz_d    = 1'b1;
    end else if (s1_za_q) begin
      result_d = '0;
    end else if (s1_d_q >= OVF_TH) begin
      result_d = {{(EXP_W-1){1'b1}}, 1'b0};
      ovf_d    = 1'b1;
    end else if (s1_d_q <= ZERO_W) begin
      result_d = EXP_W'(1);
      unf_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      if (s1_advance) begin
        s2_valid_q <= 1'b1;
        result_q   <= result_d;
        ovf_q      <= ovf_d;
        unf_q      <= unf_d;
        dbz_q      <= dbz_d;
      end else if (out_xfer) begin
        s2_valid_q <= 1'b0;
      end
    end
  end

  // A setting transfer overrides a same-cycle clear.
  always_comb begin
    ovf_sts_d = clr ? 1'b0 : ovf_sts_q;
    unf_sts_d = clr ? 1'b0 : unf_sts_q;
    if (out_xfer && ovf_q) ovf_sts_d = 1'b1;
    if (out_xfer && unf_q) unf_sts_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sts_q <= 1'b0;
      unf_sts_q <= 1'b0;
    end else begin
      ovf_sts_q <= ovf_sts_d;
      unf_sts_q <= unf_sts_d;
    end
  end

`ifdef BF16_EXP_SUB_EVCNT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clr ? 8'h00 : cnt_q;
    if (out_xfer && (ovf_q || unf_q) && (cnt_d != 8'hFF)) cnt_d = cnt_d + 8'h01;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 8'h00;
    else     cnt_q <= cnt_d;
  end

  assign evt_count = cnt_q;
`endif

  assign out_valid        = s2_valid_q;
  assign result           = result_q;
  assign res_ovf          = ovf_q;
  assign res_unf          = unf_q;
  assign res_dbz          = dbz_q;
  assign overflow_status  = ovf_sts_q;
  assign underflow_status = unf_sts_q;

endmodule

`default_nettype wire

// File: tb/tb_bf16_exp_sub.sv
// ---------------------------------------------------------------------------
// tb_bf16_exp_sub : directed table-driven bench for bf16_exp_sub.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bf16_exp_sub;

  logic       clk, rst, clr;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] exp_a, exp_b, result;
  logic       res_ovf, res_unf, res_dbz, overflow_status, underflow_status;
`ifdef BF16_EXP_SUB_EVCNT_EN
  logic [7:0] evt_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  bf16_exp_sub #(.EXP_W(8), .BIAS(127)) dut (
    .clk              (clk),
    .rst              (rst),
    .clr              (clr),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .exp_a            (exp_a),
    .exp_b            (exp_b),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .result           (result),
    .res_ovf          (res_ovf),
    .res_unf          (res_unf),
    .res_dbz          (res_dbz),
    .overflow_status  (overflow_status),
    .underflow_status (underflow_status)
`ifdef BF16_EXP_SUB_EVCNT_EN
    ,
    .evt_count        (evt_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       ovf;
    logic       unf;
    logic       dbz;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_evt(input string name, input logic [7:0] exp);
`ifdef BF16_EXP_SUB_EVCNT_EN
    check(name, {24'd0, evt_count}, {24'd0, exp});
`else
    if (exp == 8'hxx) $display("unused");
`endif
  endtask

  // One operand pair through an otherwise empty pipeline; clr optionally
  // pulsed in the same cycle as the output transfer.
  task automatic run_vec(input vec_t v, input logic clr_on_out, input string tag);
    int n;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    exp_a     = v.a;
    exp_b     = v.b;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 6) begin
      @(posedge clk); #1;
      n++;
    end
    // Accept edge loads stage 1, the following edge presents the result.
    check({tag, "_latency"}, n, 32'd1);
    check({tag, "_result"}, {24'd0, result}, {24'd0, v.res});
    check({tag, "_ovf"}, {31'd0, res_ovf}, {31'd0, v.ovf});
    check({tag, "_unf"}, {31'd0, res_unf}, {31'd0, v.unf});
    check({tag, "_dbz"}, {31'd0, res_dbz}, {31'd0, v.dbz});
    clr = clr_on_out;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bp_a[4];
    logic [7:0] bp_b[4];
    logic [7:0] bp_r[4];
    int idx, got;

    vecs[0]  = '{8'h85, 8'h81, 8'h83, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'h80, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'h81, 8'h01, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{8'hFE, 8'h01, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{8'h01, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{8'h01, 8'h80, 8'h01, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{8'h01, 8'hFE, 8'h01, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{8'h90, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{8'h00, 8'h90, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{8'h80, 8'h80, 8'h7F, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{8'h02, 8'h80, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{8'hFF, 8'h01, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{8'h01, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{8'hFF, 8'hFF, 8'h7F, 1'b0, 1'b0, 1'b0};

    bp_a = '{8'h85, 8'h90, 8'h70, 8'h82};
    bp_b = '{8'h81, 8'h80, 8'h80, 8'h7F};
    bp_r = '{8'h83, 8'h8F, 8'h6F, 8'h82};

    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    exp_a = 8'h00; exp_b = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_flags", {29'd0, res_ovf, res_unf, res_dbz}, 32'd0);
    check("rst_sticky", {30'd0, overflow_status, underflow_status}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_evt("rst_evt", 8'h00);

    for (int i = 0; i < 15; i++) run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));

    check("sticky_ovf_set", {31'd0, overflow_status}, 32'd1);
    check("sticky_unf_set", {31'd0, underflow_status}, 32'd1);
    check_evt("evt_after_table", 8'h06);

    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_ovf", {31'd0, overflow_status}, 32'd0);
    check("clr_unf", {31'd0, underflow_status}, 32'd0);
    check_evt("clr_evt", 8'h00);

    run_vec(vecs[2], 1'b1, "clr_vs_set");
    check("clr_vs_set_ovf_sts", {31'd0, overflow_status}, 32'd1);
    check("clr_vs_set_unf_sts", {31'd0, underflow_status}, 32'd0);
    check_evt("clr_vs_set_evt", 8'h01);

    // Backpressure: four pairs, sink stalled for the first four cycles.
    idx = 0;
    got = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(posedge clk); #1;
      out_ready = (cyc >= 4);
      in_valid  = (idx < 4);
      if (idx < 4) begin
        exp_a = bp_a[idx];
        exp_b = bp_b[idx];
      end
      @(negedge clk);
      if (cyc == 2) begin
        check("bp_accepted_before_stall", idx, 32'd2);
        check("bp_in_ready_stall", {31'd0, in_ready}, 32'd0);
      end
      if (cyc == 2 || cyc == 3) begin
        check($sformatf("bp_hold_valid_c%0d", cyc), {31'd0, out_valid}, 32'd1);
        check($sformatf("bp_hold_result_c%0d", cyc), {24'd0, result}, 32'h83);
      end
      if (out_valid && out_ready) begin
        if (got < 4) check($sformatf("bp_order%0d", got), {24'd0, result}, {24'd0, bp_r[got]});
        check($sformatf("bp_nogap%0d", got), cyc, 4 + got);
        got++;
      end
      if (in_valid && in_ready) idx++;
    end
    check("bp_count", got, 32'd4);
    @(posedge clk); #1;
    in_valid = 1'b0;

    run_vec(vecs[3], 1'b0, "pre_rst_ovf");
    run_vec(vecs[6], 1'b0, "pre_rst_unf");
    check("pre_rst_sticky", {30'd0, overflow_status, underflow_status}, 32'd3);
    check_evt("pre_rst_evt", 8'h03);

    // Fill both stages, then reset between clock edges.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    exp_a = 8'h81; exp_b = 8'h01;
    @(posedge clk); #1;
    exp_a = 8'h01; exp_b = 8'hFE;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid_full_valid", {31'd0, out_valid}, 32'd1);
    check("mid_full_in_ready", {31'd0, in_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_result", {24'd0, result}, 32'd0);
    check("async_rst_sticky", {30'd0, overflow_status, underflow_status}, 32'd0);
    check_evt("async_rst_evt", 8'h00);
    #1 rst = 1'b0;
    run_vec(vecs[0], 1'b0, "post_rst");
    check("post_rst_sticky", {30'd0, overflow_status, underflow_status}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bf16_exp_sub.md
Name: bf16_exp_sub

Overview:
- Exponent path of the BFLOAT16 divide datapath; the subtract-direction counterpart of the multiply-side exponent adder.
- Computes the biased quotient exponent `ea - eb + BIAS` for each operand pair.
- Classifies the result, saturates it, and drives per-result and sticky overflow/underflow status.
- Two-stage pipeline with valid/ready handshakes on both sides; feeds the divider's normalise/pack stage.

Parameters:
- EXP_W, 8, exponent width in bits.
- BIAS, 127, exponent bias added after subtraction.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear of the sticky status registers.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block accepts the operand pair this cycle.
- exp_a  input  EXP_W  biased dividend exponent.
- exp_b  input  EXP_W  biased divisor exponent.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- result  output  EXP_W  biased quotient exponent.
- res_ovf  output  1  overflow flag for the current result.
- res_unf  output  1  underflow flag for the current result.
- res_dbz  output  1  divide-by-zero flag for the current result.
- overflow_status  output  1  sticky overflow flag.
- underflow_status  output  1  sticky underflow flag.

Behaviour:
- Reset: all pipeline valids, result, res_* flags, sticky flags and the counter clear to 0 immediately (asynchronous). Reset mid-operation discards any in-flight data.
- Handshake:
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
  - in_ready = !s1_valid | s1_advance.
  - s1_advance = s1_valid & (!s2_valid | out_ready).
  - Data in a stage is held while stalled.
  - Full throughput (1/cycle) when out_ready stays high; latency 2 cycles from input transfer to out_valid.
- Stage 1 registers a signed (EXP_W+2)-bit value d = exp_a - exp_b + BIAS. It also registers za = (exp_a==0) and zb = (exp_b==0).
- Stage 2 classification, in priority order:
  - zb=1: result = all-ones (0xFF), res_dbz=1, res_ovf=0, res_unf=0.
  - za=1: result = 0x00, all flags 0.
  - d >= 2^EXP_W-1 (255): result = 0xFE, res_ovf=1.
  - d <= 0: result = 0x01, res_unf=1.
  - Otherwise: result = d[EXP_W-1:0], flags 0.
- Output stability: result and res_* hold stable while out_valid & !out_ready.
- Sticky flags:
  - On an output transfer, overflow_status |= res_ovf and underflow_status |= res_unf.
  - clr clears both on the next edge.
  - clr in the same cycle as a setting transfer: set wins (flag = 1).
- Boundaries:
  - d == 254 is valid, no flag.
  - d == 255 is overflow.
  - d == 1 is valid.
  - d == 0 is underflow.
- Simultaneous input and output transfer while both stages are full: no bubble, no loss; results stay in order.

Optional Feature:
- Macro: BF16_EXP_SUB_EVCNT_EN.
- Enabled:
  - Extra output port evt_count [7:0].
  - Increments by 1 on each output transfer with res_ovf|res_unf; saturates at 0xFF.
  - Cleared by rst and by clr; a same-cycle clr and event gives 0x01.
- Disabled: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Normal case: exp_a=0x85, exp_b=0x81, out_ready=1 -> out_valid 2 cycles later, result=0x83, all flags 0.
- Overflow boundary:
  - exp_a=0x80, exp_b=0x01 -> result=0xFE, no flag.
  - exp_a=0x81, exp_b=0x01 -> result=0xFE, res_ovf=1, overflow_status=1 after transfer.
  - exp_a=0xFE, exp_b=0x01 -> result=0xFE, res_ovf=1.
- Underflow boundary:
  - exp_a=0x01, exp_b=0x7F -> result=0x01, no flag.
  - exp_a=0x01, exp_b=0x80 -> result=0x01, res_unf=1.
  - exp_a=0x01, exp_b=0xFE -> result=0x01, res_unf=1, underflow_status=1.
  - Then pulse clr -> both sticky flags 0.
- Zero operands:
  - exp_b=0x00, exp_a=0x90 -> result=0xFF, res_dbz=1, no ovf/unf.
  - exp_a=0x00, exp_b=0x90 -> result=0x00, all flags 0.
- Backpressure: stream four pairs with out_ready held low for 4 cycles.
  - in_ready deasserts after 2 accepted pairs.
  - result stays stable during the stall.
  - After release, all four results emerge in order with no gaps.
- Reset mid-operation: assert rst with both stages valid -> out_valid, result and sticky flags go to 0 without a clock edge. After release, a new pair produces the correct result 2 cycles after transfer. With BF16_EXP_SUB_EVCNT_EN, evt_count also returns to 0.
